// File: rtl/hamming_decoder.sv
// ----------------------------------------------------------------------------
// hamming_decoder
//
// Two-stage SECDED decoder with valid/ready handshakes on both sides.
// Stage 1 registers the incoming codeword; stage 2 registers the syndrome,
// the single/double error flags and the corrected payload.
//
// Codeword layout: bit 0 is the extended (overall) parity bit, bits at
// positions 2**k are Hamming parity bits, and every other position from 3
// upwards carries payload, lowest position to data_o[0].
//
// Optional feature macro: HAMMING_DECODER_ERR_CNT_EN
//   defined   -> saturating 16-bit single/double error counters are built
//   undefined -> sec_cnt_o / ded_cnt_o are tied to 0 and cnt_clr_i is ignored
//
// Ports
//   clk_i        clock, all state on the rising edge
//   rst_i        asynchronous active-high reset
//   in_valid_i   codeword valid
//   in_ready_o   decoder can accept a codeword this cycle
//   code_i       SECDED codeword (CODED_WIDTH bits)
//   out_valid_o  decoded result valid
//   out_ready_i  downstream accepts the result
//   data_o       corrected payload
//   sec_o        single error corrected
//   ded_o        uncorrectable (double) error detected
//   err_pos_o    syndrome; flipped bit index when sec_o=1 and non-zero
//   cnt_clr_i    synchronous clear of the error counters
//   sec_cnt_o    single-error counter
//   ded_cnt_o    double-error counter
// ----------------------------------------------------------------------------

// Smallest p with 2**p >= dw+p+1; the fixed point is reached within three
// $clog2 iterations for any payload width.
`ifndef HAMMING_ADDR_WIDTH
`define HAMMING_ADDR_WIDTH(dw) ($clog2((dw) + 1 + $clog2((dw) + 1 + $clog2((dw) + 1))))
`endif

module hamming_decoder #(
    parameter int DATA_WIDTH = 32,
    localparam int ADDR_WIDTH = `HAMMING_ADDR_WIDTH(DATA_WIDTH),
    localparam int CODED_WIDTH = DATA_WIDTH + ADDR_WIDTH + 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [CODED_WIDTH-1:0] code_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [DATA_WIDTH-1:0]  data_o,
    output logic                   sec_o,
    output logic                   ded_o,
    output logic [ADDR_WIDTH-1:0]  err_pos_o,
    input  logic                   cnt_clr_i,
    output logic [15:0]            sec_cnt_o,
    output logic [15:0]            ded_cnt_o
);

    // Codeword position that carries payload bit d.
    function automatic int data_pos(input int d);
        int pos;
        int cnt;
        pos = 0;
        cnt = 0;
        for (int i = 3; i < CODED_WIDTH; i++) begin
            if ((i & (i - 1)) != 0) begin
                if (cnt == d) begin
                    pos = i;
                end
                cnt++;
            end
        end
        return pos;
    endfunction

    logic                   en;
    logic                   s1_valid_q, s1_valid_d;
    logic [CODED_WIDTH-1:0] s1_code_q, s1_code_d;
    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   sec_q, sec_d;
    logic                   ded_q, ded_d;
    logic [ADDR_WIDTH-1:0]  err_pos_q, err_pos_d;

    logic [ADDR_WIDTH-1:0]  syndrome;
    logic                   parity;
    logic                   flip;
    logic                   sec_next;
    logic                   ded_next;
    logic [CODED_WIDTH-1:0] corrected;
    logic [DATA_WIDTH-1:0]  data_next;

    // The whole pipeline moves together whenever the output register is
    // empty or being drained this cycle.
    assign en = !out_valid_q || out_ready_i;
    assign in_ready_o = en;

    // Syndrome, overall parity and error classification of the stage-1 word.
    // A non-zero syndrome with odd parity that points past the codeword can
    // only come from three or more flips, so it is reported as uncorrectable.
    always_comb begin
        syndrome = '0;
        for (int i = 1; i < CODED_WIDTH; i++) begin
            if (s1_code_q[i]) begin
                syndrome = syndrome ^ ADDR_WIDTH'(i);
            end
        end
        parity   = ^s1_code_q;
        flip     = 1'b0;
        sec_next = 1'b0;
        ded_next = 1'b0;
        if (syndrome == '0) begin
            sec_next = parity;
        end else if (parity) begin
            if (int'(syndrome) < CODED_WIDTH) begin
                sec_next = 1'b1;
                flip     = 1'b1;
            end else begin
                ded_next = 1'b1;
            end
        end else begin
            ded_next = 1'b1;
        end
        corrected = s1_code_q ^ (flip ? (CODED_WIDTH'(1) << syndrome) : '0);
    end

    // Payload extraction is pure wiring from fixed codeword positions.
    for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_extract
        localparam int POS = data_pos(g);
        assign data_next[g] = corrected[POS];
    end

    // Parity positions of the corrected word are intentionally dropped.
    logic unused_corrected;
    assign unused_corrected = ^corrected;

    // Next-state for both pipeline stages; everything holds while stalled so
    // the presented result stays stable until it is taken.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_code_d   = s1_code_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        sec_d       = sec_q;
        ded_d       = ded_q;
        err_pos_d   = err_pos_q;
        if (en) begin
            s1_valid_d  = in_valid_i;
            if (in_valid_i) begin
                s1_code_d = code_i;
            end
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                data_d    = data_next;
                sec_d     = sec_next;
                ded_d     = ded_next;
                err_pos_d = syndrome;
            end
        end
    end

    // Pipeline registers; reset discards any word in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_code_q   <= '0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            sec_q       <= 1'b0;
            ded_q       <= 1'b0;
            err_pos_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_code_q   <= s1_code_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            sec_q       <= sec_d;
            ded_q       <= ded_d;
            err_pos_q   <= err_pos_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign data_o      = data_q;
    assign sec_o       = sec_q;
    assign ded_o       = ded_q;
    assign err_pos_o   = err_pos_q;

`ifdef HAMMING_DECODER_ERR_CNT_EN
    logic        out_fire;
    logic [15:0] sec_cnt_q, sec_cnt_d;
    logic [15:0] ded_cnt_q, ded_cnt_d;

    assign out_fire = out_valid_q && out_ready_i;

    // Count each delivered result once; clear wins over a same-cycle count.
    always_comb begin
        sec_cnt_d = sec_cnt_q;
        ded_cnt_d = ded_cnt_q;
        if (cnt_clr_i) begin
            sec_cnt_d = '0;
            ded_cnt_d = '0;
        end else if (out_fire) begin
            if (sec_q && (sec_cnt_q != 16'hFFFF)) begin
                sec_cnt_d = sec_cnt_q + 16'd1;
            end
            if (ded_q && (ded_cnt_q != 16'hFFFF)) begin
                ded_cnt_d = ded_cnt_q + 16'd1;
            end
        end
    end

    // Error counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sec_cnt_q <= '0;
            ded_cnt_q <= '0;
        end else begin
            sec_cnt_q <= sec_cnt_d;
            ded_cnt_q <= ded_cnt_d;
        end
    end

    assign sec_cnt_o = sec_cnt_q;
    assign ded_cnt_o = ded_cnt_q;
`else
    logic unused_cnt_clr;
    assign unused_cnt_clr = cnt_clr_i;
    assign sec_cnt_o = '0;
    assign ded_cnt_o = '0;
`endif

endmodule
